// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared defaults and FSM encodings for the instruction fetch
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int          c_XLEN_DEFAULT         = 32;
    localparam logic [31:0] c_NOP                  = 32'h0000_0013;
    localparam logic [31:0] c_RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of {pc, inst} entries; flush beats push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full      = (r_count == c_CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;

    // Storage is reset so the head output reads zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage - PC, FSM, instruction memory and
//               fetch queue presented to decode over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               XLEN         = c_XLEN_DEFAULT,
    parameter int               IMEM_DEPTH   = 1024,
    parameter int               FQ_DEPTH     = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(c_RESET_VECTOR_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [XLEN-1:0]               inst_data,
    output logic [XLEN-1:0]               inst_pc,
    output logic                          misalign_err,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata
);

    localparam int c_AW = $clog2(IMEM_DEPTH);
    localparam int c_CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_inflight_pc;
    logic              r_inflight;
    logic              r_misalign;
    logic [XLEN-1:0]   r_rdata;
    logic [XLEN-1:0]   r_imem [IMEM_DEPTH];

    logic [c_CW-1:0]   w_count;
    logic [c_CW-1:0]   w_occupancy;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic              w_push;
    logic [2*XLEN-1:0] w_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE: if (fetch_en)  w_state_next = FETCH_RUN;
            FETCH_RUN:  if (!fetch_en) w_state_next = FETCH_IDLE;
            default:    w_state_next = FETCH_IDLE;
        endcase
    end

    // A pop in this cycle is deliberately not credited to keep the path short.
    assign w_occupancy = w_count + c_CW'(r_inflight);
    assign w_issue     = (r_state == FETCH_RUN) && !redirect_valid && !w_full &&
                         (w_occupancy < c_CW'(FQ_DEPTH));
    assign w_push      = r_inflight && !redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_VECTOR;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_fetch_pc    <= r_fetch_pc + XLEN'(4);
                    r_inflight_pc <= r_fetch_pc;
                end
            end
        end
    end

    // Program contents survive reset; a same-word read sees the old value.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
        if (w_issue) begin
            r_rdata <= r_imem[r_fetch_pc[c_AW+1:2]];
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (2*XLEN)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (inst_valid && inst_ready),
        .flush     (redirect_valid),
        .push_data ({r_inflight_pc, r_rdata}),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign inst_valid   = !w_empty;
    assign inst_pc      = w_head[2*XLEN-1:XLEN];
    assign inst_data    = w_head[XLEN-1:0];
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit (16-word memory).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int c_XLEN  = 32;
    localparam int c_DEPTH = 16;
    localparam int c_FQ    = 4;

    logic              clk            = 1'b0;
    logic              reset          = 1'b0;
    logic              fetch_en       = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [c_XLEN-1:0] redirect_pc    = '0;
    logic              inst_ready     = 1'b0;
    logic              imem_we        = 1'b0;
    logic [3:0]        imem_waddr     = '0;
    logic [c_XLEN-1:0] imem_wdata     = '0;
    logic              inst_valid;
    logic [c_XLEN-1:0] inst_data;
    logic [c_XLEN-1:0] inst_pc;
    logic              misalign_err;

    logic [31:0] ref_mem [c_DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN         (c_XLEN),
        .IMEM_DEPTH   (c_DEPTH),
        .FQ_DEPTH     (c_FQ),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return ref_mem[pc[5:2]];
    endfunction

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 32'(inst_valid), 32'd1);
        check({tag, ".pc"},    inst_pc,         pc);
        check({tag, ".data"},  inst_data,       word_at(pc));
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < c_DEPTH; i++) begin
            ref_mem[i] = (i < 4) ? 32'(8'h11 * (i + 1)) : (32'hA000_0000 + 32'(i));
        end
        for (int i = 0; i < c_DEPTH; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 4'(i);
            imem_wdata = ref_mem[i];
            tick();
        end
        imem_we = 1'b0;

        check("rst.valid",    32'(inst_valid),   32'd0);
        check("rst.pc",       inst_pc,           32'd0);
        check("rst.data",     inst_data,         32'd0);
        check("rst.misalign", 32'(misalign_err), 32'd0);

        // cycle 0: release with fetch enabled
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        reset      = 1'b1;
        tick();
        tick();
        check("startup.c2.valid", 32'(inst_valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_head("startup", 32'(4 * k));
            tick();
        end

        // back-pressure from cycle 7, head pc 0x10
        check_head("bp.start", 32'h10);
        inst_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_head("bp.hold", 32'h10);
        end
        check("bp.count",    32'(dut.w_count), 32'(c_FQ));
        check("bp.fetch_pc", dut.r_fetch_pc,   32'h20);
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_head("bp.drain", 32'h10 + 32'(4 * k));
            tick();
        end

        // fill the queue, then redirect
        inst_ready = 1'b0;
        repeat (4) tick();
        check("redir.full", 32'(dut.w_count), 32'(c_FQ));
        redirect_to(32'h100);
        inst_ready = 1'b1;
        check("redir.n1.valid",    32'(inst_valid),   32'd0);
        check("redir.n1.misalign", 32'(misalign_err), 32'd0);
        tick();
        check("redir.n2.valid", 32'(inst_valid), 32'd0);
        tick();
        check_head("redir.n3", 32'h100);
        tick();
        check_head("redir.n4", 32'h104);

        // misaligned redirect
        redirect_to(32'h102);
        check("mis.n1.pulse", 32'(misalign_err), 32'd1);
        check("mis.n1.valid", 32'(inst_valid),   32'd0);
        tick();
        check("mis.n2.pulse", 32'(misalign_err), 32'd0);
        tick();
        check_head("mis.n3", 32'h100);

        // wrap past the 16-word memory
        redirect_to(32'h3C);
        tick();
        tick();
        check_head("alias.3c", 32'h3C);
        tick();
        check_head("alias.40", 32'h40);

        // asynchronous reset mid-stream
        inst_ready = 1'b0;
        tick();
        tick();
        check("areset.pre.valid", 32'(inst_valid), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("areset.valid",    32'(inst_valid),   32'd0);
        check("areset.pc",       inst_pc,           32'd0);
        check("areset.data",     inst_data,         32'd0);
        check("areset.misalign", 32'(misalign_err), 32'd0);
        tick();
        reset      = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        check("restart.c2.valid", 32'(inst_valid), 32'd0);
        tick();
        check_head("restart.c3", 32'h0);
        tick();
        check_head("restart.c4", 32'h4);

        // fetch disabled: in-flight data lands, queue drains, nothing new
        fetch_en = 1'b0;
        tick();
        check_head("noen.c5", 32'h8);
        tick();
        check_head("noen.c6", 32'hC);
        tick();
        check("noen.c7.valid", 32'(inst_valid), 32'd0);
        tick();
        check("noen.c8.valid", 32'(inst_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
